// File: rtl/bin_to_7seg_display_if.sv
// Load/busy/done handshake and display bus between a value producer and the 7-segment driver.
interface bin_to_7seg_display_if #(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 3
);
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  load;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output bin_in, load,
    input  busy, done, overflow, seg_out
  );

  modport slave (
    input  bin_in, load,
    output busy, done, overflow, seg_out
  );
endinterface

// File: rtl/bin_to_7seg_display.sv
// Sequential binary-to-BCD (double dabble, one bit per clock) driving DIGITS common-anode displays,
// with overflow dashes and optional leading-zero blanking.
module bin_to_7seg_display #(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bin_to_7seg_display_if.slave  bus
);

  function automatic int unsigned max_val(input int unsigned d);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned MaxVal  = max_val(DIGITS);
  localparam int unsigned CmpW    = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;
  localparam int unsigned CntW    = $clog2(BIN_WIDTH + 1);
  localparam int unsigned BcdW    = 4 * DIGITS;
  localparam int unsigned SegW    = 7 * DIGITS;
  localparam logic [CntW-1:0] CntInit = CntW'(BIN_WIDTH);
  localparam logic [6:0] Dash  = 7'b0111111;
  localparam logic [6:0] Blank = 7'b1111111;

  function automatic logic [6:0] dec_digit(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = Dash;
    endcase
    return s;
  endfunction

  typedef enum logic {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BcdW-1:0]      bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [SegW-1:0]      seg_q, seg_d, seg_dec;
  logic                 hi_zero;
  logic [3:0]           nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  // Digit decode with leading-zero blanking, scanned from the most significant digit down.
  always_comb begin
    seg_dec = '1;
    hi_zero = 1'b1;
    nib     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = bcd_q[4*k +: 4];
      if ((BLANK_LZ != 0) && (k > 0) && hi_zero && (nib == 4'd0)) begin
        seg_dec[7*k +: 7] = Blank;
      end else begin
        seg_dec[7*k +: 7] = dec_digit(nib);
      end
      if (nib != 4'd0) hi_zero = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    seg_d      = seg_q;

    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          bin_d      = bus.bin_in;
          bcd_d      = '0;
          cnt_d      = CntInit;
          ovf_pend_d = CmpW'(bus.bin_in) > CmpW'(MaxVal);
          state_d    = StShift;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          // Bits leaving the top of the BCD register are dropped; overflow is flagged separately.
          {bcd_d, bin_d} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q - 1'b1;
        end else begin
          seg_d   = ovf_pend_q ? {DIGITS{Dash}} : seg_dec;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy     = (state_q == StShift);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.seg_out  = seg_q;

endmodule

// File: tb/tb_bin_to_7seg_display.sv
// Scoreboard bench: two drivers (blanking on/off) share stimulus; a monitor checks every done.
module tb_bin_to_7seg_display;

  typedef struct {
    logic [20:0] seg;
    bit          ovf;
    int          lcyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q_b[$];
  exp_t q_n[$];
  logic [20:0] last_b;
  logic [20:0] last_n;

  bin_to_7seg_display_if #(.BIN_WIDTH(10), .DIGITS(3)) if_b ();
  bin_to_7seg_display_if #(.BIN_WIDTH(10), .DIGITS(3)) if_n ();

  bin_to_7seg_display #(.BIN_WIDTH(10), .DIGITS(3), .BLANK_LZ(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  bin_to_7seg_display #(.BIN_WIDTH(10), .DIGITS(3), .BLANK_LZ(0)) u_dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Reference: decimal digits by division; a digit above the ones is blank when value < 10^k.
  function automatic logic [20:0] model(input int v, input bit blank);
    logic [20:0] s;
    int p;
    if (v > 999) return {3{7'b0111111}};
    p = 1;
    for (int k = 0; k < 3; k++) begin
      if (blank && k > 0 && v < p) s[7*k +: 7] = 7'b1111111;
      else                         s[7*k +: 7] = glyph((v / p) % 10);
      p = p * 10;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit ld, input logic [9:0] v);
    if_b.load   = ld;
    if_n.load   = ld;
    if_b.bin_in = v;
    if_n.bin_in = v;
  endtask

  task automatic do_load(input int v);
    exp_t e;
    int n;
    n = 0;
    while (if_b.busy && n < 50) begin
      step();
      n++;
    end
    if (if_b.busy) chk("busy_wait_timeout", 32'(if_b.busy), 0);
    drive(1'b1, 10'(v));
    e.ovf  = (v > 999);
    e.lcyc = cyc + 1;
    e.seg  = model(v, 1'b1);
    q_b.push_back(e);
    e.seg  = model(v, 1'b0);
    q_n.push_back(e);
    step();
    drive(1'b0, 10'($urandom_range(0, 1023)));
    chk("busy_after_load_b", 32'(if_b.busy), 1);
    chk("busy_after_load_n", 32'(if_n.busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!if_b.done && n < 40) begin
      step();
      n++;
    end
    if (!if_b.done) chk("done_timeout", 32'(if_b.done), 1);
  endtask

  // Monitor: compare every done against the scoreboard; otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst) begin
      last_b = '1;
      last_n = '1;
    end else begin
      if (if_b.done) begin
        if (q_b.size() == 0) begin
          chk("unexpected_done_b", 32'(if_b.done), 0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          chk("seg_b", 32'(if_b.seg_out), 32'(e.seg));
          chk("ovf_b", 32'(if_b.overflow), 32'(e.ovf));
          chk("busy_at_done_b", 32'(if_b.busy), 0);
          chk("latency_b", 32'(cyc - e.lcyc), 11);
          last_b = e.seg;
        end
      end else begin
        chk("seg_hold_b", 32'(if_b.seg_out), 32'(last_b));
      end
      if (if_n.done) begin
        if (q_n.size() == 0) begin
          chk("unexpected_done_n", 32'(if_n.done), 0);
        end else begin
          exp_t e;
          e = q_n.pop_front();
          chk("seg_n", 32'(if_n.seg_out), 32'(e.seg));
          chk("ovf_n", 32'(if_n.overflow), 32'(e.ovf));
          last_n = e.seg;
        end
      end else begin
        chk("seg_hold_n", 32'(if_n.seg_out), 32'(last_n));
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_seg_b", 32'(if_b.seg_out), 32'h1FFFFF);
    chk("rst_seg_n", 32'(if_n.seg_out), 32'h1FFFFF);
    chk("rst_busy", 32'(if_b.busy), 0);
    chk("rst_done", 32'(if_b.done), 0);
    chk("rst_ovf", 32'(if_b.overflow), 0);
  endtask

  initial begin
    int v;
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 10'd0);
    step();
    step();
    check_reset_vals();
    rst = 1'b0;
    step();

    do_load(123); wait_done();
    do_load(999); wait_done();
    do_load(7);   wait_done();
    do_load(0);   wait_done();
    do_load(40);  wait_done();
    do_load(1000); wait_done();
    do_load(1023); wait_done();
    chk("ovf_held", 32'(if_b.overflow), 1);
    do_load(5);   wait_done();

    // Load while busy must be dropped; load in the done cycle must be taken.
    do_load(456);
    step();
    step();
    drive(1'b1, 10'd789);
    step();
    drive(1'b0, 10'd0);
    wait_done();
    do_load(789); wait_done();

    // Reset mid-conversion discards the result.
    do_load(321);
    step();
    step();
    step();
    rst = 1'b1;
    q_b.delete();
    q_n.delete();
    step();
    step();
    check_reset_vals();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(if_b.busy), 0);
    do_load(321); wait_done();

    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                      : int'($urandom_range(0, 1023));
      do_load(v);
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
      end else begin
        n = $urandom_range(0, 14);
        for (int j = 0; j < n; j++) step();
      end
    end

    n = 0;
    while ((q_b.size() != 0 || q_n.size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk("queue_b_drained", 32'(q_b.size()), 0);
    chk("queue_n_drained", 32'(q_n.size()), 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
